// File: rtl/vram_commit_buffer.sv
// Frame-synchronised VRAM write buffer: CPU writes queue in a FIFO and drain to the
// VRAM CPU port only inside a fixed-length commit window opened by frameDrawn.
`timescale 1ns/1ps

module vram_commit_buffer #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int WINDOW = 1024
) (
    input  logic                     clkPixel,
    input  logic                     nreset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     frameDrawn,
    output logic [ADDR_W-1:0]        vram_addr,
    output logic [DATA_W-1:0]        vram_d,
    output logic                     vram_we,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     committing
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WIN_W   = 16;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW);

    typedef enum logic {
        FILL,
        COMMIT
    } state_e;

    state_e              state_q,     state_d;
    logic [WIN_W-1:0]    win_q,       win_d;
    logic [PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]    count_q,     count_d;
    logic [ADDR_W-1:0]   vram_addr_q, vram_addr_d;
    logic [DATA_W-1:0]   vram_d_q,    vram_d_d;
    logic                vram_we_q,   vram_we_d;

    logic [ENTRY_W-1:0]  mem_q [DEPTH];
    logic [ENTRY_W-1:0]  rd_entry;
    logic                push;
    logic                pop;

    // Acceptance looks only at registered occupancy, so a full FIFO refuses a
    // write even on a cycle that frees a slot.
    assign wr_ready = (count_q != CNT_FULL);
    assign push     = wr_valid && wr_ready;
    assign pop      = (state_q == COMMIT) && (count_q != '0);
    assign rd_entry = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        win_d       = win_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        vram_addr_d = vram_addr_q;
        vram_d_d    = vram_d_q;
        vram_we_d   = pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            vram_addr_d = rd_entry[ENTRY_W-1:DATA_W];
            vram_d_d    = rd_entry[DATA_W-1:0];
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            FILL: begin
                if (frameDrawn) begin
                    state_d = COMMIT;
                    win_d   = WIN_LOAD;
                end
            end
            COMMIT: begin
                // A new frame pulse extends the window rather than stacking a second one.
                if (frameDrawn) begin
                    win_d = WIN_LOAD;
                end else if (win_q == WIN_W'(1)) begin
                    state_d = FILL;
                    win_d   = '0;
                end else begin
                    win_d = win_q - WIN_W'(1);
                end
            end
            default: begin
                state_d = FILL;
                win_d   = '0;
            end
        endcase
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clkPixel or negedge nreset) begin
        if (!nreset) begin
            state_q     <= FILL;
            win_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            vram_addr_q <= '0;
            vram_d_q    <= '0;
            vram_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            vram_addr_q <= vram_addr_d;
            vram_d_q    <= vram_d_d;
            vram_we_q   <= vram_we_d;
        end
    end

    // NOTE: storage is not reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clkPixel) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_addr, wr_data};
        end
    end

    assign vram_addr  = vram_addr_q;
    assign vram_d     = vram_d_q;
    assign vram_we    = vram_we_q;
    assign count      = count_q;
    assign committing = (state_q == COMMIT);

endmodule

// File: tb/tb_vram_commit_buffer.sv
// Self-checking bench for vram_commit_buffer: vector table plus hand-written
// multi-cycle sequences, with a scoreboard queue checking every VRAM commit.
`timescale 1ns/1ps

module tb_vram_commit_buffer;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int WINDOW = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic                clkPixel;
    logic                nreset;
    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                frameDrawn;
    logic [ADDR_W-1:0]   vram_addr;
    logic [DATA_W-1:0]   vram_d;
    logic                vram_we;
    logic [CNT_W-1:0]    count;
    logic                committing;

    vram_commit_buffer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .WINDOW(WINDOW)
    ) dut (
        .clkPixel  (clkPixel),
        .nreset    (nreset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frameDrawn(frameDrawn),
        .vram_addr (vram_addr),
        .vram_d    (vram_d),
        .vram_we   (vram_we),
        .count     (count),
        .committing(committing)
    );

    initial clkPixel = 1'b0;
    always #5 clkPixel = ~clkPixel;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    typedef struct {
        logic              wv;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              fd;
        int                cnt;
        logic              we;
        logic              comm;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   commits_seen = 0;
    int   seq          = 0;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every committed word must match the oldest outstanding push.
    always @(negedge clkPixel) begin
        if (nreset && vram_we) begin
            commits_seen++;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_commit: addr 0x%0h data 0x%0h with empty scoreboard", vram_addr, vram_d);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit_addr", 64'(vram_addr), 64'(mon_e.a));
                check("commit_data", 64'(vram_d), 64'(mon_e.d));
            end
        end
    end

    task automatic step(input logic wv, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic fd);
        wr_valid   = wv;
        wr_addr    = a;
        wr_data    = d;
        frameDrawn = fd;
        @(posedge clkPixel);
        #1;
        wr_valid   = 1'b0;
        frameDrawn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    // Accepted push with a repeating address set, so same-address writes must all land.
    task automatic push_seq(input logic fd);
        wr_t e;
        e.a = ADDR_W'(seq % 5);
        e.d = 32'hC0DE_0000 | 32'(seq);
        seq++;
        exp_q.push_back(e);
        step(1'b1, e.a, e.d, fd);
    endtask

    task automatic check_state(input string tag, input int cnt, input logic we, input logic comm);
        check({tag, "_count"}, 64'(count), 64'(cnt));
        check({tag, "_wr_ready"}, 64'(wr_ready), 64'(cnt != DEPTH));
        check({tag, "_vram_we"}, 64'(vram_we), 64'(we));
        check({tag, "_committing"}, 64'(committing), 64'(comm));
    endtask

    initial begin
        int c0;

        vecs[0] = '{1'b1, 14'h0100, 32'hA0A0_0000, 1'b0, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 14'h0101, 32'hA1A1_1111, 1'b0, 2, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 14'h0102, 32'hA2A2_2222, 1'b0, 3, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 14'h0000, 32'h0,         1'b0, 3, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 14'h0000, 32'h0,         1'b1, 3, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 14'h0000, 32'h0,         1'b0, 2, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 14'h0000, 32'h0,         1'b0, 1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 14'h0000, 32'h0,         1'b0, 0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 14'h0000, 32'h0,         1'b0, 0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 14'h0000, 32'h0,         1'b0, 0, 1'b0, 1'b0};

        nreset     = 1'b0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        frameDrawn = 1'b0;
        #12;
        check_state("reset", 0, 1'b0, 1'b0);
        check("reset_vram_addr", 64'(vram_addr), 64'h0);
        check("reset_vram_d", 64'(vram_d), 64'h0);
        @(negedge clkPixel);
        nreset = 1'b1;
        @(posedge clkPixel);
        #1;

        // Three writes held in FILL, then one window drains them in order.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wv) exp_q.push_back('{vecs[i].a, vecs[i].d});
            step(vecs[i].wv, vecs[i].a, vecs[i].d, vecs[i].fd);
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].we, vecs[i].comm);
        end

        // Fill to DEPTH; the extra write is refused, including on a popping cycle.
        for (int i = 0; i < DEPTH; i++) begin
            push_seq(1'b0);
            check($sformatf("fill_count%0d", i), 64'(count), 64'(i + 1));
        end
        step(1'b1, 14'h3FFF, 32'hDEAD_BEEF, 1'b0);
        check_state("full_hold", DEPTH, 1'b0, 1'b0);
        for (int w = 0; w < 4; w++) begin
            step(1'b0, '0, '0, 1'b1);
            step(w == 0, 14'h3FFE, 32'hBAD0_BAD0, 1'b0);
            if (w == 0) check("full_pop_cycle_count", 64'(count), 64'(DEPTH - 1));
            idle(4);
            check($sformatf("drain_window%0d_count", w), 64'(count), 64'(DEPTH - 4 * (w + 1)));
        end

        // Ten entries across three short windows: 4, 4, then 2.
        for (int i = 0; i < 10; i++) push_seq(1'b0);
        for (int w = 0; w < 3; w++) begin
            c0 = commits_seen;
            step(1'b0, '0, '0, 1'b1);
            idle(5);
            check($sformatf("window%0d_commits", w), 64'(commits_seen - c0), 64'((w < 2) ? 4 : 2));
            check_state($sformatf("window%0d", w), (w < 2) ? 6 - 4 * w : 0, 1'b0, 1'b0);
        end

        // Streaming: push every cycle while draining; window kept open by reloads.
        for (int i = 0; i < 3; i++) push_seq(1'b0);
        step(1'b0, '0, '0, 1'b1);
        check_state("stream_open", 3, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            push_seq(i % 2 == 1);
            check_state($sformatf("stream%0d", i), 3, 1'b1, 1'b1);
        end
        idle(6);
        check_state("stream_end", 0, 1'b0, 1'b0);
        check("stream_scoreboard", 64'(exp_q.size()), 64'h0);

        // Reset in the middle of a commit window discards everything at once.
        for (int i = 0; i < 5; i++) push_seq(1'b0);
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0);
        check("pre_reset_vram_we", 64'(vram_we), 64'h1);
        nreset = 1'b0;
        #1;
        check_state("mid_reset", 0, 1'b0, 1'b0);
        exp_q.delete();
        @(negedge clkPixel);
        nreset = 1'b1;
        c0 = commits_seen;
        step(1'b0, '0, '0, 1'b1);
        idle(WINDOW + 2);
        check("post_reset_commits", 64'(commits_seen - c0), 64'h0);
        check_state("post_reset", 0, 1'b0, 1'b0);

        check("final_scoreboard", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
